// File: rtl/mem_bus_router_if.sv
// Shared encodings plus the bus bundle between the CPU memory stage, the router and its RAM/GPIO targets.
// Encodings track the CPU's common constants (exception codes and access widths).
`timescale 1ns/1ps

package mem_bus_router_pkg;
  localparam int EXCEPTION_LEN = 4;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK                = 4'd0;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ  = 4'd5;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = 4'd7;
  localparam logic [1:0] MEM_WIDTH_NONE = 2'd0;
  localparam logic [1:0] MEM_WIDTH_BYTE = 2'd1;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'd2;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd3;
endpackage

interface mem_bus_router_if;
  logic        req_valid_In;
  logic [31:0] req_addr_In;
  logic [31:0] req_data_In;
  logic [1:0]  req_width_In;
  logic        req_isRead_In;
  logic        req_signed_In;
  logic        req_ready_Out;
  logic        resp_valid_Out;
  logic [31:0] resp_data_Out;
  logic [mem_bus_router_pkg::EXCEPTION_LEN-1:0] resp_exception_Out;

  logic [31:0] ram_addr_Out;
  logic [31:0] ram_data_Out;
  logic [1:0]  ram_dataWidth_Out;
  logic        ram_isRead_Out;
  logic        ram_inputValid_Out;
  logic [31:0] ram_data_In;
  logic        ram_operationOK_In;
  logic [mem_bus_router_pkg::EXCEPTION_LEN-1:0] ram_exception_In;

  logic [31:0] io_addr_Out;
  logic [31:0] io_data_Out;
  logic [1:0]  io_dataWidth_Out;
  logic        io_isRead_Out;
  logic        io_inputValid_Out;
  logic [31:0] io_data_In;
  logic        io_operationOK_In;
  logic [mem_bus_router_pkg::EXCEPTION_LEN-1:0] io_exception_In;

  // Router side.
  modport slave (
    input  req_valid_In, req_addr_In, req_data_In, req_width_In, req_isRead_In, req_signed_In,
    output req_ready_Out, resp_valid_Out, resp_data_Out, resp_exception_Out,
    output ram_addr_Out, ram_data_Out, ram_dataWidth_Out, ram_isRead_Out, ram_inputValid_Out,
    input  ram_data_In, ram_operationOK_In, ram_exception_In,
    output io_addr_Out, io_data_Out, io_dataWidth_Out, io_isRead_Out, io_inputValid_Out,
    input  io_data_In, io_operationOK_In, io_exception_In
  );

  // CPU and target side.
  modport master (
    output req_valid_In, req_addr_In, req_data_In, req_width_In, req_isRead_In, req_signed_In,
    input  req_ready_Out, resp_valid_Out, resp_data_Out, resp_exception_Out,
    input  ram_addr_Out, ram_data_Out, ram_dataWidth_Out, ram_isRead_Out, ram_inputValid_Out,
    output ram_data_In, ram_operationOK_In, ram_exception_In,
    input  io_addr_Out, io_data_Out, io_dataWidth_Out, io_isRead_Out, io_inputValid_Out,
    output io_data_In, io_operationOK_In, io_exception_In
  );
endinterface

// File: rtl/mem_bus_router.sv
// Single-outstanding load/store router: decode/check, one-cycle target strobe, bounded wait for
// the target's OK, load-data extension and a one-cycle response with exception code.
`timescale 1ns/1ps

module mem_bus_router #(
  parameter logic [31:0] IO_BASE  = 32'h1000_0000,
  parameter logic [31:0] IO_SIZE  = 32'd4,
  parameter logic [31:0] RAM_BASE = 32'h8000_0000,
  parameter logic [31:0] RAM_SIZE = 32'h0001_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input logic             clk,
  input logic             rst,
  mem_bus_router_if.slave bus
);
  import mem_bus_router_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t                   r_state, w_state_next;
  logic [31:0]              r_offset, w_offset_next;
  logic [31:0]              r_data, w_data_next;
  logic [1:0]               r_width, w_width_next;
  logic                     r_is_read, w_is_read_next;
  logic                     r_signed, w_signed_next;
  logic                     r_sel_io, w_sel_io_next;
  logic                     r_sel_ram, w_sel_ram_next;
  logic [31:0]              r_resp_data, w_resp_data_next;
  logic [EXCEPTION_LEN-1:0] r_resp_exc, w_resp_exc_next;
  logic [7:0]               r_cnt, w_cnt_next;

  logic [2:0]               w_bytes;
  logic                     w_misalign;
  logic [32:0]              w_io_off, w_ram_off, w_io_end, w_ram_end;
  logic                     w_io_ok, w_ram_ok, w_fault;
  logic                     w_sel_ok;
  logic [EXCEPTION_LEN-1:0] w_sel_exc;
  logic [31:0]              w_sel_rdata, w_load_ext;
  logic [EXCEPTION_LEN-1:0] w_bad_code;

  // Address decode and legality of the incoming request (33-bit math keeps the borrow visible).
  always_comb begin
    w_bytes = 3'd0;
    unique case (bus.req_width_In)
      MEM_WIDTH_BYTE: w_bytes = 3'd1;
      MEM_WIDTH_HALF: w_bytes = 3'd2;
      MEM_WIDTH_WORD: w_bytes = 3'd4;
      default:        w_bytes = 3'd0;
    endcase
    w_misalign = ((bus.req_width_In == MEM_WIDTH_HALF) && bus.req_addr_In[0]) ||
                 ((bus.req_width_In == MEM_WIDTH_WORD) && (bus.req_addr_In[1:0] != 2'b00));
    w_io_off  = {1'b0, bus.req_addr_In} - {1'b0, IO_BASE};
    w_ram_off = {1'b0, bus.req_addr_In} - {1'b0, RAM_BASE};
    w_io_end  = w_io_off + {30'd0, w_bytes};
    w_ram_end = w_ram_off + {30'd0, w_bytes};
    w_io_ok   = !w_io_off[32] && (w_io_off[31:0] < IO_SIZE) && (w_io_end <= {1'b0, IO_SIZE});
    w_ram_ok  = !w_ram_off[32] && (w_ram_off[31:0] < RAM_SIZE) && (w_ram_end <= {1'b0, RAM_SIZE});
    w_fault   = (w_bytes == 3'd0) || w_misalign || !(w_io_ok || w_ram_ok);
  end

  // Only the selected target's return signals are ever looked at.
  always_comb begin
    w_sel_ok    = 1'b0;
    w_sel_exc   = EXCEP_OK;
    w_sel_rdata = bus.ram_data_In;
    if (r_sel_io) begin
      w_sel_ok    = bus.io_operationOK_In;
      w_sel_exc   = bus.io_exception_In;
      w_sel_rdata = bus.io_data_In;
    end else if (r_sel_ram) begin
      w_sel_ok    = bus.ram_operationOK_In;
      w_sel_exc   = bus.ram_exception_In;
      w_sel_rdata = bus.ram_data_In;
    end
    w_load_ext = w_sel_rdata;
    unique case (r_width)
      MEM_WIDTH_BYTE: w_load_ext = {{24{r_signed & w_sel_rdata[7]}}, w_sel_rdata[7:0]};
      MEM_WIDTH_HALF: w_load_ext = {{16{r_signed & w_sel_rdata[15]}}, w_sel_rdata[15:0]};
      default:        w_load_ext = w_sel_rdata;
    endcase
    w_bad_code = r_is_read ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_offset    <= '0;
      r_data      <= '0;
      r_width     <= '0;
      r_is_read   <= 1'b0;
      r_signed    <= 1'b0;
      r_sel_io    <= 1'b0;
      r_sel_ram   <= 1'b0;
      r_resp_data <= '0;
      r_resp_exc  <= EXCEP_OK;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_offset    <= w_offset_next;
      r_data      <= w_data_next;
      r_width     <= w_width_next;
      r_is_read   <= w_is_read_next;
      r_signed    <= w_signed_next;
      r_sel_io    <= w_sel_io_next;
      r_sel_ram   <= w_sel_ram_next;
      r_resp_data <= w_resp_data_next;
      r_resp_exc  <= w_resp_exc_next;
      r_cnt       <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_offset_next    = r_offset;
    w_data_next      = r_data;
    w_width_next     = r_width;
    w_is_read_next   = r_is_read;
    w_signed_next    = r_signed;
    w_sel_io_next    = r_sel_io;
    w_sel_ram_next   = r_sel_ram;
    w_resp_data_next = r_resp_data;
    w_resp_exc_next  = r_resp_exc;
    w_cnt_next       = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid_In) begin
          w_data_next      = bus.req_data_In;
          w_width_next     = bus.req_width_In;
          w_is_read_next   = bus.req_isRead_In;
          w_signed_next    = bus.req_signed_In;
          w_resp_data_next = '0;
          if (w_fault) begin
            w_sel_io_next   = 1'b0;
            w_sel_ram_next  = 1'b0;
            w_offset_next   = '0;
            w_resp_exc_next = bus.req_isRead_In ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
            w_state_next    = S_RESP;
          end else begin
            w_sel_io_next   = w_io_ok;
            w_sel_ram_next  = !w_io_ok;
            w_offset_next   = w_io_ok ? w_io_off[31:0] : w_ram_off[31:0];
            w_resp_exc_next = EXCEP_OK;
            w_state_next    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (w_sel_exc != EXCEP_OK) begin
          w_resp_exc_next = w_sel_exc;
          w_state_next    = S_RESP;
        end else begin
          w_cnt_next   = '0;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_sel_ok) begin
          w_resp_data_next = r_is_read ? w_load_ext : 32'd0;
          w_resp_exc_next  = EXCEP_OK;
          w_state_next     = S_RESP;
        end else if (r_cnt == LAST_WAIT) begin
          w_resp_exc_next = w_bad_code;
          w_state_next    = S_RESP;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_RESP: begin
        w_sel_io_next  = 1'b0;
        w_sel_ram_next = 1'b0;
        w_state_next   = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.req_ready_Out      = (r_state == S_IDLE);
  assign bus.resp_valid_Out     = (r_state == S_RESP);
  assign bus.resp_data_Out      = r_resp_data;
  assign bus.resp_exception_Out = r_resp_exc;

  // Unselected target sees all-zero fields, not just a low strobe.
  assign bus.io_inputValid_Out  = (r_state == S_ISSUE) && r_sel_io;
  assign bus.io_addr_Out        = r_sel_io ? r_offset : 32'd0;
  assign bus.io_data_Out        = r_sel_io ? r_data : 32'd0;
  assign bus.io_dataWidth_Out   = r_sel_io ? r_width : 2'd0;
  assign bus.io_isRead_Out      = r_sel_io && r_is_read;

  assign bus.ram_inputValid_Out = (r_state == S_ISSUE) && r_sel_ram;
  assign bus.ram_addr_Out       = r_sel_ram ? r_offset : 32'd0;
  assign bus.ram_data_Out       = r_sel_ram ? r_data : 32'd0;
  assign bus.ram_dataWidth_Out  = r_sel_ram ? r_width : 2'd0;
  assign bus.ram_isRead_Out     = r_sel_ram && r_is_read;

endmodule

// File: doc/mem_bus_router.md
# mem_bus_router

Load/store router between the CPU memory stage and the memory-mapped targets (RAM, GPIO `IO` block). It accepts one request at a time, decodes and checks the address, and issues a single-cycle `inputValid` strobe to the selected target with the window-relative offset. It then waits for `operationOK` with a timeout, extends load data and returns one response with an exception code. All exception codes and width encodings come from `src/constants.v`: `EXCEP_*` and `MEM_WIDTH_NONE/BYTE/HALF/WORD`.

## Interface
- `IO_BASE`, 32'h1000_0000, base of GPIO window
- `IO_SIZE`, 4, GPIO window size in bytes
- `RAM_BASE`, 32'h8000_0000, base of RAM window
- `RAM_SIZE`, 32'h0001_0000, RAM window size in bytes
- `TIMEOUT`, 16, maximum cycles spent in WAIT, range 1..255
- `clk` in 1 clock
- `rst` in 1 reset, synchronous, active-high
- `req_valid_In` in 1 CPU request strobe
- `req_addr_In` in 32 byte address
- `req_data_In` in 32 store data, right-aligned
- `req_width_In` in 2 `MEM_WIDTH_*`
- `req_isRead_In` in 1: 1 = load, 0 = store
- `req_signed_In` in 1: load sign-extend (1) or zero-extend (0)
- `req_ready_Out` out 1: high only in IDLE
- `resp_valid_Out` out 1: one-cycle response strobe
- `resp_data_Out` out 32: extended load data; 0 for stores and faults
- `resp_exception_Out` out `EXCEPTION_LEN`: `EXCEP_OK` or fault code
- Per target, with prefixes `ram_` and `io_`:
  - `addr_Out` out 32: offset, i.e. address − base
  - `data_Out` out 32
  - `dataWidth_Out` out 2
  - `isRead_Out` out 1
  - `inputValid_Out` out 1
  - `data_In` in 32
  - `operationOK_In` in 1
  - `exception_In` in `EXCEPTION_LEN`, combinational from target

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from the state.
- **IDLE**
  - `req_ready_Out`=1. A request is accepted on `req_valid_In`; address, data, width, isRead and signed are latched.
  - Decode: hit if base ≤ addr < base+size. An address in neither window is a fault.
  - Further fault checks:
    - width `MEM_WIDTH_NONE`
    - HALF with addr[0]≠0
    - WORD with addr[1:0]≠0
    - access crossing the window end
  - On a fault, go to RESP with `EXCEP_INVALID_MEM_READ` (load) or `EXCEP_INVALID_MEM_WRITE` (store). No target is touched.
  - Otherwise go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - The selected target sees `inputValid_Out`=1 plus the latched fields, with addr = offset. The unselected target sees `inputValid_Out`=0.
  - If the selected `exception_In` ≠ `EXCEP_OK` this cycle, capture it and go to RESP.
  - Otherwise clear the timeout counter and go to WAIT.
- **WAIT**
  - On `operationOK_In` from the selected target:
    - load: extend `data_In` per width and signed (BYTE from [7:0], HALF from [15:0], WORD unchanged)
    - store: data = 0
    - go to RESP with `EXCEP_OK`
  - Otherwise increment the counter. After `TIMEOUT` WAIT cycles without OK, go to RESP with the invalid-read/write code.
- **RESP**: `resp_valid_Out`=1 for one cycle, then IDLE.
- `operationOK_In` outside WAIT, or from the unselected target, is ignored.
- `req_valid_In` outside IDLE is ignored; the CPU holds the request until it sees `req_ready_Out`.

## Timing
- Reset values:
  - state IDLE
  - `req_ready_Out`=1
  - `resp_valid_Out`=0, `resp_data_Out`=0, `resp_exception_Out`=`EXCEP_OK`
  - all `*_inputValid_Out`=0, all other target outputs 0
  - counter 0
- Reset mid-operation: return to IDLE next edge. A pending target response is dropped and no `resp_valid_Out` is produced.
- Latency from the accepting edge (cycle 0):
  - decode fault: `resp_valid_Out` in cycle 1
  - target exception: `resp_valid_Out` in cycle 2
  - target answering k cycles after the ISSUE cycle (k ≥ 1): `resp_valid_Out` in cycle 2+k. The GPIO target has k=1, so its response is in cycle 3.
  - timeout: `resp_valid_Out` in cycle 2+`TIMEOUT`
- `inputValid_Out` is high for exactly one cycle per accepted legal request, and never for a faulted one.
- Throughput: one request per 2 (fault) to 4+ cycles. Back-to-back acceptance is possible the cycle after RESP.

## Test plan
- **IO byte load, signed**: load of 0x1000_0001, BYTE, signed, with IO returning 0x0000_0080 one cycle after the strobe.
  - `io_addr_Out`=1, `io_inputValid_Out` high 1 cycle
  - resp in cycle 3: data 0xFFFF_FF80, `EXCEP_OK`
  - unsigned variant returns 0x0000_0080
- **IO word store**: store of 0xDEADBEEF to 0x1000_0000, WORD.
  - `io_data_Out`=0xDEADBEEF, `io_isRead_Out`=0
  - resp data 0, `EXCEP_OK`
  - `ram_inputValid_Out` never asserted
- **Decode and alignment faults**
  - load 0x2000_0000 → resp cycle 1, `EXCEP_INVALID_MEM_READ`, no target strobe
  - store HALF to 0x8000_0003 → `EXCEP_INVALID_MEM_WRITE`
  - WORD store to 0x1000_0002 → `EXCEP_INVALID_MEM_WRITE`
- **Target exception**: RAM drives `EXCEP_INVALID_MEM_READ` during ISSUE → resp cycle 2 with that code, data 0.
- **Timeout**: RAM never asserts OK, `TIMEOUT`=16 → resp in cycle 18 with the invalid code, then `req_ready_Out`=1. A late OK after that is ignored.
- **Reset mid-WAIT**: assert `rst` in cycle 2 of an IO load → IDLE, all outputs at reset values, no `resp_valid_Out`. The next request completes normally.
